cpu_mem_arbiter: RTL and testbench

- Shares the single-port 64 KB BSRAM between two requesters: the 6809 bus (CPU port) and the UART monitor/loader (LD port).
- The CPU port always has priority. Loader accesses fill idle sys_clk slots between E cycles.
- The block sequences memory timing, returns read data and enforces the ROM write-protect window for CPU writes.
- It sits between the E-edge bus synchroniser and the memory array.

---
 rtl/cpu_mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - CPU/loader arbiter for the shared single-port BSRAM (optional WP_TRAP_EN)
module cpu_mem_arbiter #(
    parameter int          MEM_LAT = 2,
    parameter logic [15:0] WP_BASE = 16'h8000
) (
    input  logic        sys_clk,
    input  logic        RESET_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_overrun,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic [7:0]  ld_rdata,
    output logic        ld_ack,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
`ifdef WP_TRAP_EN
    ,
    output logic        wp_hit,
    output logic [15:0] wp_addr
`endif
);

    typedef enum logic [1:0] {IDLE, CPU_WAIT, LD_WAIT} state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic        cpu_pend_q, cpu_pend_d;
    logic        slot_we_q, slot_we_d;
    logic [15:0] slot_addr_q, slot_addr_d;
    logic [7:0]  slot_wdata_q, slot_wdata_d;
    logic        cpu_overrun_q, cpu_overrun_d;
    logic        cpu_done_q, cpu_done_d;
    logic        ld_ack_q, ld_ack_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  ld_rdata_q, ld_rdata_d;
    logic        wp_hit_q, wp_hit_d;
    logic [15:0] wp_addr_q, wp_addr_d;

    logic        issue_cpu, issue_ld;
    logic        iss_we;
    logic [15:0] iss_addr;
    logic [7:0]  iss_wdata;
    logic        iss_prot;

    // A fresh cpu_req overrides the slot, so issue straight from the bus when present
    always_comb begin
        iss_we    = cpu_req ? cpu_we    : slot_we_q;
        iss_addr  = cpu_req ? cpu_addr  : slot_addr_q;
        iss_wdata = cpu_req ? cpu_wdata : slot_wdata_q;
        iss_prot  = (iss_addr >= WP_BASE);
    end

    // Next-state: CPU capture, arbitration, latency countdown and completion
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        cpu_pend_d    = cpu_pend_q;
        slot_we_d     = slot_we_q;
        slot_addr_d   = slot_addr_q;
        slot_wdata_d  = slot_wdata_q;
        cpu_overrun_d = cpu_overrun_q;
        cpu_done_d    = 1'b0;
        ld_ack_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = mem_wdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        ld_rdata_d    = ld_rdata_q;
        wp_hit_d      = wp_hit_q;
        wp_addr_d     = wp_addr_q;
        issue_cpu     = 1'b0;
        issue_ld      = 1'b0;

        if (cpu_req) begin
            slot_we_d    = cpu_we;
            slot_addr_d  = cpu_addr;
            slot_wdata_d = cpu_wdata;
            cpu_pend_d   = 1'b1;
            if (cpu_pend_q) begin
                cpu_overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (cpu_pend_q || cpu_req) begin
                    issue_cpu = 1'b1;
                end else if (ld_req) begin
                    issue_ld = 1'b1;
                end
            end
            CPU_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    cpu_rdata_d = mem_rdata;
                    cpu_done_d  = 1'b1;
                    if (cpu_req) begin
                        issue_cpu = 1'b1;
                    end else begin
                        cpu_pend_d = 1'b0;
                        if (ld_req) begin
                            issue_ld = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            LD_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    ld_rdata_d = mem_rdata;
                    ld_ack_d   = 1'b1;
                    // ld_req is still held this cycle, so only the CPU may follow directly
                    if (cpu_pend_q || cpu_req) begin
                        issue_cpu = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_cpu) begin
            mem_addr_d  = iss_addr;
            mem_wdata_d = iss_wdata;
            mem_we_d    = iss_we && !iss_prot;
            lat_cnt_d   = LAT_INIT;
            state_d     = CPU_WAIT;
            if (iss_we && iss_prot && !wp_hit_q) begin
                wp_hit_d  = 1'b1;
                wp_addr_d = iss_addr;
            end
        end else if (issue_ld) begin
            mem_addr_d  = ld_addr;
            mem_wdata_d = ld_wdata;
            mem_we_d    = ld_we;
            lat_cnt_d   = LAT_INIT;
            state_d     = LD_WAIT;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!RESET_n) begin
            state_q       <= IDLE;
            lat_cnt_q     <= 2'd0;
            cpu_pend_q    <= 1'b0;
            slot_we_q     <= 1'b0;
            slot_addr_q   <= 16'h0000;
            slot_wdata_q  <= 8'h00;
            cpu_overrun_q <= 1'b0;
            cpu_done_q    <= 1'b0;
            ld_ack_q      <= 1'b0;
            mem_addr_q    <= 16'h0000;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= 8'h00;
            cpu_rdata_q   <= 8'h00;
            ld_rdata_q    <= 8'h00;
            wp_hit_q      <= 1'b0;
            wp_addr_q     <= 16'h0000;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            cpu_pend_q    <= cpu_pend_d;
            slot_we_q     <= slot_we_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdata_q  <= slot_wdata_d;
            cpu_overrun_q <= cpu_overrun_d;
            cpu_done_q    <= cpu_done_d;
            ld_ack_q      <= ld_ack_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            ld_rdata_q    <= ld_rdata_d;
            wp_hit_q      <= wp_hit_d;
            wp_addr_q     <= wp_addr_d;
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_done    = cpu_done_q;
    assign cpu_overrun = cpu_overrun_q;
    assign ld_rdata    = ld_rdata_q;
    assign ld_ack      = ld_ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;

`ifdef WP_TRAP_EN
    assign wp_hit  = wp_hit_q;
    assign wp_addr = wp_addr_q;
`else
    logic unused_wp;
    assign unused_wp = ^{wp_hit_q, wp_addr_q};
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

    logic        sys_clk = 1'b0;
    logic        RESET_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic [7:0]  cpu_rdata;
    logic        cpu_done;
    logic        cpu_overrun;
    logic        ld_req = 1'b0;
    logic        ld_we = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [7:0]  ld_wdata = 8'h0;
    logic [7:0]  ld_rdata;
    logic        ld_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h0;
`ifdef WP_TRAP_EN
    logic        wp_hit;
    logic [15:0] wp_addr;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0] mem [0:65535];

    always #5 sys_clk = ~sys_clk;

    // Synchronous-read BSRAM model: address registered by the DUT, data one cycle later
    always @(posedge sys_clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    cpu_mem_arbiter #(.MEM_LAT(2), .WP_BASE(16'h8000)) dut (
        .sys_clk(sys_clk), .RESET_n(RESET_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_overrun(cpu_overrun),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef WP_TRAP_EN
        , .wp_hit(wp_hit), .wp_addr(wp_addr)
`endif
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic ld_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                             output logic [7:0] rd, output int lat, output int wec);
        ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
        lat = 0; wec = 0;
        do begin
            tick; lat++;
            if (mem_we) wec++;
        end while (!ld_ack && lat < 20);
        rd = ld_rdata;
        ld_req = 1'b0; ld_we = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int lat, output int wec);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        tick; lat = 1; wec = mem_we ? 1 : 0;
        cpu_req = 1'b0; cpu_we = 1'b0;
        while (!cpu_done && lat < 20) begin
            tick; lat++;
            if (mem_we) wec++;
        end
        rd = cpu_rdata;
    endtask

    initial begin
        logic [7:0] rd;
        int lat, wec, cnt;

        // Reset state
        RESET_n = 1'b0;
        tick; tick;
        check("rst_cpu_done", cpu_done, 0);
        check("rst_ld_ack", ld_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ld_rdata", ld_rdata, 0);
        check("rst_overrun", cpu_overrun, 0);
`ifdef WP_TRAP_EN
        check("rst_wp_hit", wp_hit, 0);
`endif
        RESET_n = 1'b1;
        tick;

        // Loader write then read of 0x1234
        ld_access(1'b1, 16'h1234, 8'h5A, rd, lat, wec);
        check("ldw_lat", lat, 3);
        check("ldw_we_cycles", wec, 1);
        tick;
        check("ldw_ack_pulse", ld_ack, 0);
        ld_access(1'b0, 16'h1234, 8'h00, rd, lat, wec);
        check("ldr_lat", lat, 3);
        check("ldr_we_cycles", wec, 0);
        check("ldr_data", rd, 8'h5A);
        tick;

        // Preload via loader
        ld_access(1'b1, 16'h0100, 8'hC3, rd, lat, wec); tick;
        ld_access(1'b1, 16'h8000, 8'h11, rd, lat, wec); tick;
        ld_access(1'b1, 16'h7FFF, 8'h22, rd, lat, wec); tick;
        ld_access(1'b1, 16'h3000, 8'h00, rd, lat, wec); tick;

        // Idle CPU read
        cpu_access(1'b0, 16'h0100, 8'h00, rd, lat, wec);
        check("cpur_lat", lat, 3);
        check("cpur_data", rd, 8'hC3);
        tick;
        check("cpur_done_pulse", cpu_done, 0);

        // cpu_req one cycle after a loader issue
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h1234;
        tick;
        check("cc_ld_issue_addr", mem_addr, 16'h1234);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        tick; cnt = 1;
        cpu_req = 1'b0;
        check("cc_no_early_ack", ld_ack, 0);
        tick; cnt++;
        check("cc_ld_ack", ld_ack, 1);
        check("cc_ld_data", ld_rdata, 8'h5A);
        check("cc_cpu_no_gap", mem_addr, 16'h0100);
        check("cc_cpu_done_after_ack", cpu_done, 0);
        ld_req = 1'b0;
        while (!cpu_done && cnt < 20) begin tick; cnt++; end
        check("cc_cpu_lat_le5", (cnt <= 5) ? 1 : 0, 1);
        check("cc_cpu_data", cpu_rdata, 8'hC3);
        check("cc_no_overrun", cpu_overrun, 0);
        tick;

        // Write-protect window
        cpu_access(1'b1, 16'h8000, 8'hFF, rd, lat, wec);
        check("wp_done", cpu_done, 1);
        check("wp_we_cycles", wec, 0);
        tick;
        cpu_access(1'b1, 16'h7FFF, 8'hFF, rd, lat, wec);
        check("wr_done", cpu_done, 1);
        check("wr_we_cycles", wec, 1);
        tick;
        ld_access(1'b0, 16'h8000, 8'h00, rd, lat, wec);
        check("wp_mem_8000", rd, 8'h11);
        tick;
        ld_access(1'b0, 16'h7FFF, 8'h00, rd, lat, wec);
        check("wr_mem_7fff", rd, 8'hFF);
        tick;
`ifdef WP_TRAP_EN
        check("wp_hit", wp_hit, 1);
        check("wp_addr", wp_addr, 16'h8000);
`endif

        // Two cpu_req pulses during a loader access
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h2000; ld_wdata = 8'h77;
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h33;
        tick;
        check("ov_first_no_flag", cpu_overrun, 0);
        cpu_addr = 16'h3100; cpu_wdata = 8'h44;
        tick;
        check("ov_ld_ack", ld_ack, 1);
        check("ov_flag", cpu_overrun, 1);
        check("ov_issue_addr", mem_addr, 16'h3100);
        check("ov_issue_we", mem_we, 1);
        ld_req = 1'b0; ld_we = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cnt = 0;
        while (!cpu_done && cnt < 20) begin tick; cnt++; end
        check("ov_cpu_done", cpu_done, 1);
        tick;
        check("ov_sticky", cpu_overrun, 1);
        ld_access(1'b0, 16'h3100, 8'h00, rd, lat, wec);
        check("ov_mem_3100", rd, 8'h44);
        tick;
        ld_access(1'b0, 16'h3000, 8'h00, rd, lat, wec);
        check("ov_mem_3000", rd, 8'h00);
        tick;
        ld_access(1'b0, 16'h2000, 8'h00, rd, lat, wec);
        check("ov_mem_2000", rd, 8'h77);
        tick;

        // Reset during LD_WAIT aborts the access
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h1234;
        tick;
        RESET_n = 1'b0; ld_req = 1'b0;
        tick;
        check("ra_ld_ack", ld_ack, 0);
        check("ra_ld_rdata", ld_rdata, 0);
        check("ra_mem_addr", mem_addr, 0);
        check("ra_overrun", cpu_overrun, 0);
        check("ra_cpu_rdata", cpu_rdata, 0);
        RESET_n = 1'b1;
        tick;
        tick;
        check("ra_no_late_ack", ld_ack, 0);
        ld_access(1'b0, 16'h1234, 8'h00, rd, lat, wec);
        check("ra_retry_lat", lat, 3);
        check("ra_retry_data", rd, 8'h5A);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
